// File: rtl/msb_normalizer_pkg.sv
// Shared definitions for the MSB detector / normalizer pair: FSM encodings
// and the default word and position widths.
package msb_normalizer_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int POS_W_DEF = 6;
    localparam int STEP_DEF  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/msb_normalizer_step_shifter.sv
// Single-step left shifter with zero fill at the LSB end.
// The caller limits amt to at most STEP, so the shifter only ever moves a
// word by one step's worth of bits.
module msb_normalizer_step_shifter #(
    parameter int WIDTH = 32,
    parameter int POS_W = 6
) (
    input  logic [WIDTH-1:0] mant,
    input  logic [POS_W-1:0] amt,
    output logic [WIDTH-1:0] shifted
);

    // Logical shift left: zeros enter at bit 0.
    assign shifted = mant << amt;

endmodule

// File: rtl/msb_normalizer.sv
// Left-justifies a data word so its leading one lands in bit WIDTH-1.
// The MSB position comes from the upstream detector and is trusted.
// The shift is spread over several clocks, at most STEP bits per clock.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. in_ready is high only in IDLE. out_valid is
// high only in DONE, and the results stay stable until out_ready is seen.
// The block never accepts a new job in the same cycle it hands one off.
module msb_normalizer
    import msb_normalizer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int POS_W = POS_W_DEF,
    parameter int STEP  = STEP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [POS_W-1:0] in_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [POS_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_err,
    output logic [1:0]       dbg_state
);

    localparam logic [POS_W-1:0] WIDTH_P = POS_W'(WIDTH);
    localparam logic [POS_W-1:0] STEP_P  = POS_W'(STEP);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mant;
    logic [POS_W-1:0] rem;
    logic [POS_W-1:0] amt;
    logic [WIDTH-1:0] mant_shifted;
    logic             accept;
    logic             pos_zero;
    logic             pos_err;

    assign accept   = in_valid && in_ready;
    assign pos_zero = (in_pos == '0);
    assign pos_err  = (in_pos > WIDTH_P);

    // The shift for this cycle is min(rem, STEP), so rem can never underflow.
    assign amt = (rem > STEP_P) ? STEP_P : rem;

    msb_normalizer_step_shifter #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_step_shifter (
        .mant    (mant),
        .amt     (amt),
        .shifted (mant_shifted)
    );

    // State register; a reset abandons any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    // Zero words, out-of-range positions and words that are
                    // already justified need no shifting at all.
                    if (pos_zero || pos_err || (in_pos == WIDTH_P)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                // This is the last step when what remains fits in one step.
                if (rem <= STEP_P) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture the job on accept, then shift it down to rem == 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant     <= '0;
            rem      <= '0;
            out_exp  <= '0;
            out_zero <= 1'b0;
            out_err  <= 1'b0;
        end else if (accept) begin
            if (pos_zero) begin
                mant     <= '0;
                rem      <= '0;
                out_exp  <= '0;
                out_zero <= 1'b1;
                out_err  <= 1'b0;
            end else if (pos_err) begin
                // Out-of-range position: pass the word through unshifted.
                mant     <= in_data;
                rem      <= '0;
                out_exp  <= WIDTH_P;
                out_zero <= 1'b0;
                out_err  <= 1'b1;
            end else begin
                mant     <= in_data;
                rem      <= WIDTH_P - in_pos;
                out_exp  <= in_pos;
                out_zero <= 1'b0;
                out_err  <= 1'b0;
            end
        end else if (state == S_SHIFT) begin
            mant <= mant_shifted;
            rem  <= rem - amt;
        end
    end

    assign out_mant  = mant;
    assign dbg_state = state;

endmodule

// File: tb/tb_msb_normalizer.sv
// Directed bench for msb_normalizer with WIDTH=32, POS_W=6 and STEP=8.
// Expected results are worked out by hand in the job table below.
module tb_msb_normalizer;
    import msb_normalizer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  in_pos;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_mant;
    logic [5:0]  out_exp;
    logic        out_zero;
    logic        out_err;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    msb_normalizer #(
        .WIDTH (32),
        .POS_W (6),
        .STEP  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_pos    (in_pos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_err   (out_err),
        .dbg_state (dbg_state)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Moves to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one job, measures latency and checks the result; then accepts it.
    task automatic run_job(input string tag, input logic [31:0] d, input logic [5:0] p,
                           input logic [31:0] e_mant, input logic [5:0] e_exp,
                           input logic e_zero, input logic e_err, input int e_lat);
        int lat;
        logic [31:0] want;
        exp_q.push_back(e_mant);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_pos   = p;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(e_lat));
        want = exp_q.pop_front();
        check({tag, "_mant"}, 64'(out_mant), 64'(want));
        check({tag, "_exp"}, 64'(out_exp), 64'(e_exp));
        check({tag, "_zero"}, 64'(out_zero), 64'(e_zero));
        check({tag, "_err"}, 64'(out_err), 64'(e_err));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drained"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_pos    = '0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mant", 64'(out_mant), 64'd0);
        check("rst_exp", 64'(out_exp), 64'd0);
        check("rst_zero", 64'(out_zero), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        rst_n = 1'b1;
        tick();

        // out_ready while nothing is valid has no effect.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_ready_ignored", 64'(out_valid), 64'd0);
        check("idle_state", 64'(dbg_state), 64'(S_IDLE));

        // Already justified, single bit at the bottom, mid position, zero word.
        run_job("pos32", 32'h8000_0000, 6'd32, 32'h8000_0000, 6'd32, 1'b0, 1'b0, 1);
        run_job("pos1",  32'h0000_0001, 6'd1,  32'h8000_0000, 6'd1,  1'b0, 1'b0, 5);
        run_job("pos17", 32'h0001_2345, 6'd17, 32'h91A2_8000, 6'd17, 1'b0, 1'b0, 3);
        run_job("zero",  32'h0000_0000, 6'd0,  32'h0000_0000, 6'd0,  1'b1, 1'b0, 1);
        // rem = 24: exactly three full steps.
        run_job("pos8",  32'h0000_00AB, 6'd8,  32'hAB00_0000, 6'd8,  1'b0, 1'b0, 4);
        // rem = 7: one partial step.
        run_job("pos25", 32'h0123_4567, 6'd25, 32'h91A2_B380, 6'd25, 1'b0, 1'b0, 2);

        // Result held in DONE while the consumer stalls; new offers ignored.
        check("hold_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = 32'h0001_2345;
        in_pos   = 6'd17;
        tick();
        in_data  = 32'hFFFF_FFFF;
        in_pos   = 6'd3;
        tick();
        tick();
        check("hold_reach_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_mant", 64'(out_mant), 64'h91A2_8000);
            check("hold_exp", 64'(out_exp), 64'd17);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_release", 64'(in_ready), 64'd1);

        // Reset pulsed mid-shift discards the job immediately.
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        in_pos   = 6'd1;
        tick();
        in_valid = 1'b0;
        tick();
        check("midrst_shifting", 64'(dbg_state), 64'(S_SHIFT));
        rst_n = 1'b0;
        #1;
        check("midrst_state", 64'(dbg_state), 64'(S_IDLE));
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_mant", 64'(out_mant), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Out-of-range position, then a normal job to see the flag cleared.
        run_job("err40", 32'hDEAD_BEEF, 6'd40, 32'hDEAD_BEEF, 6'd32, 1'b0, 1'b1, 1);
        run_job("after_err", 32'h0000_0003, 6'd2, 32'hC000_0000, 6'd2, 1'b0, 1'b0, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
